// File: rtl/voxel_pkg.sv
// Shared definitions for the voxel address map and its readers: scan FSM states,
// address-width helper and the coordinate-width limits both sides must respect.
package voxel_pkg;

    localparam int unsigned COORD_BITS_MIN = 1;
    localparam int unsigned COORD_BITS_MAX = 16;
    localparam int unsigned ADDR_BITS_MAX  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    function automatic int unsigned addr_width(input int unsigned x_bits,
                                               input int unsigned y_bits,
                                               input int unsigned z_bits);
        return x_bits + y_bits + z_bits;
    endfunction

    function automatic bit coord_bits_ok(input int unsigned bits);
        return (bits >= COORD_BITS_MIN) && (bits <= COORD_BITS_MAX);
    endfunction

endpackage

// File: rtl/voxel_addr_unmap.sv
// Combinational linear address -> (x,y,z) decode; the inverse of the voxel address
// packing. MAP_ZYX selects {z,y,x} (1) or {x,y,z} (0) field order.
module voxel_addr_unmap
    import voxel_pkg::*;
#(
    parameter  int unsigned X_BITS    = 5,
    parameter  int unsigned Y_BITS    = 5,
    parameter  int unsigned Z_BITS    = 5,
    parameter  bit          MAP_ZYX   = 1'b1,
    localparam int unsigned ADDR_BITS = addr_width(X_BITS, Y_BITS, Z_BITS)
) (
    input  logic [ADDR_BITS-1:0] addr,
    output logic [X_BITS-1:0]    x,
    output logic [Y_BITS-1:0]    y,
    output logic [Z_BITS-1:0]    z
);

    generate
        if (MAP_ZYX) begin : g_zyx
            assign x = addr[X_BITS-1:0];
            assign y = addr[X_BITS +: Y_BITS];
            assign z = addr[X_BITS+Y_BITS +: Z_BITS];
        end else begin : g_xyz
            assign z = addr[Z_BITS-1:0];
            assign y = addr[Z_BITS +: Y_BITS];
            assign x = addr[Z_BITS+Y_BITS +: X_BITS];
        end
    endgenerate

endmodule

// File: rtl/voxel_scan_walker.sv
// Sequential voxel address walker: emits one (addr,x,y,z) beat per address of a run
// over a valid/ready stream. Optional abort input enabled by VOXEL_SCAN_ABORT_EN.
module voxel_scan_walker
    import voxel_pkg::*;
#(
    parameter  int unsigned X_BITS    = 5,
    parameter  int unsigned Y_BITS    = 5,
    parameter  int unsigned Z_BITS    = 5,
    parameter  bit          MAP_ZYX   = 1'b1,
    localparam int unsigned ADDR_BITS = addr_width(X_BITS, Y_BITS, Z_BITS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] start_addr,
    input  logic [ADDR_BITS:0]   count,
`ifdef VOXEL_SCAN_ABORT_EN
    input  logic                 abort,
`endif
    output logic                 busy,
    output logic                 done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ADDR_BITS-1:0] out_addr,
    output logic [X_BITS-1:0]    out_x,
    output logic [Y_BITS-1:0]    out_y,
    output logic [Z_BITS-1:0]    out_z,
    output logic                 out_last
);

    generate
        if (!coord_bits_ok(X_BITS) || !coord_bits_ok(Y_BITS) || !coord_bits_ok(Z_BITS)) begin : g_bad_coord
            $error("voxel_scan_walker: coordinate widths must be within 1..16");
        end
        if (ADDR_BITS > ADDR_BITS_MAX) begin : g_bad_addr
            $error("voxel_scan_walker: total address width exceeds 32 bits");
        end
    endgenerate

    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   REM_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   REM_FULL = {1'b1, {ADDR_BITS{1'b0}}};

    logic abort_req;
`ifdef VOXEL_SCAN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    scan_state_t          state, next_state;
    logic [ADDR_BITS-1:0] cur_addr, nxt_addr;
    logic [ADDR_BITS:0]   remaining, nxt_rem;
    logic                 busy_d, done_d, valid_d, last_d;

    // NOTE: every register, datapath included, takes the async reset so that a
    // reset mid-run returns all outputs to zero without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops
            // update from the same pre-edge values.
            state <= next_state;
        end
    end

    // Next-state logic; counts above 2^ADDR_BITS are clamped when loaded.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latches).
        next_state = state;
        nxt_addr   = cur_addr;
        nxt_rem    = remaining;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        next_state = RUN;
                        nxt_addr   = start_addr;
                        nxt_rem    = count[ADDR_BITS] ? REM_FULL : count;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            RUN: begin
                if (out_ready) begin
                    nxt_addr = cur_addr + ADDR_ONE;
                    nxt_rem  = remaining - REM_ONE;
                end
                if (abort_req || (out_ready && remaining == REM_ONE)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output values for the coming cycle, registered below.
    always_comb begin
        busy_d  = (next_state != IDLE);
        done_d  = (next_state == DONE);
        valid_d = (next_state == RUN);
        last_d  = (next_state == RUN) && (nxt_rem == REM_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_addr  <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            cur_addr  <= nxt_addr;
            remaining <= nxt_rem;
            busy      <= busy_d;
            done      <= done_d;
            out_valid <= valid_d;
            out_last  <= last_d;
        end
    end

    assign out_addr = cur_addr;

    voxel_addr_unmap #(
        .X_BITS  (X_BITS),
        .Y_BITS  (Y_BITS),
        .Z_BITS  (Z_BITS),
        .MAP_ZYX (MAP_ZYX)
    ) u_unmap (
        .addr (cur_addr),
        .x    (out_x),
        .y    (out_y),
        .z    (out_z)
    );

endmodule

// File: tb/tb_voxel_scan_walker.sv
// Directed self-checking bench for voxel_scan_walker (5/5/5), one instance per
// packing order; abort steps are compiled only with VOXEL_SCAN_ABORT_EN.
module tb_voxel_scan_walker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [14:0] start_addr;
    logic [15:0] count;
    logic        out_ready;
`ifdef VOXEL_SCAN_ABORT_EN
    logic        abort;
`endif

    logic        busy, done, out_valid, out_last;
    logic [14:0] out_addr;
    logic [4:0]  out_x, out_y, out_z;

    logic        busy0, done0, out_valid0, out_last0;
    logic [14:0] out_addr0;
    logic [4:0]  out_x0, out_y0, out_z0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    voxel_scan_walker #(.X_BITS(5), .Y_BITS(5), .Z_BITS(5), .MAP_ZYX(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
`ifdef VOXEL_SCAN_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_z      (out_z),
        .out_last   (out_last)
    );

    voxel_scan_walker #(.X_BITS(5), .Y_BITS(5), .Z_BITS(5), .MAP_ZYX(1'b0)) dut_xyz (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .count      (count),
`ifdef VOXEL_SCAN_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy0),
        .done       (done0),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_addr   (out_addr0),
        .out_x      (out_x0),
        .out_y      (out_y0),
        .out_z      (out_z0),
        .out_last   (out_last0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [14:0] a, input logic [4:0] x,
                              input logic [4:0] y, input logic [4:0] z, input logic last);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".addr"},  out_addr, a);
        check({tag, ".xyz"},   {out_x, out_y, out_z}, {x, y, z});
        check({tag, ".last"},  out_last, last);
    endtask

    initial begin
        logic [14:0] exp_addr;
        logic [14:0] prev_addr;
        logic [15:0] prev_xyz;
        logic        prev_last;
        logic        stalled;
        logic        got_done;
        logic [14:0] last_addr;
        int          hs;
        int          beats;
        int          seq_err;
        int          last_cnt;

        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        count      = '0;
        out_ready  = 1'b0;
`ifdef VOXEL_SCAN_ABORT_EN
        abort      = 1'b0;
`endif
        #12;
        check("rst.busy", busy, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.valid", out_valid, 1'b0);
        check("rst.last", out_last, 1'b0);
        check("rst.addr", out_addr, 15'h0);
        check("rst.xyz", {out_x, out_y, out_z}, 15'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic run of three beats with the consumer always ready.
        start = 1'b1; start_addr = 15'h0421; count = 16'd3; out_ready = 1'b1;
        tick();
        start = 1'b0;
        check("b0.busy", busy, 1'b1);
        check_beat("b0", 15'h0421, 5'd1, 5'd1, 5'd1, 1'b0);
        tick();
        check_beat("b1", 15'h0422, 5'd2, 5'd1, 5'd1, 1'b0);
        tick();
        check_beat("b2", 15'h0423, 5'd3, 5'd1, 5'd1, 1'b1);
        tick();
        check("b.done", done, 1'b1);
        check("b.busy_done", busy, 1'b1);
        check("b.valid_off", out_valid, 1'b0);
        tick();
        check("b.done_off", done, 1'b0);
        check("b.idle", busy, 1'b0);

        // Address wrap at the top of the space.
        start = 1'b1; start_addr = 15'h7FFF; count = 16'd2;
        tick();
        start = 1'b0;
        check_beat("w0", 15'h7FFF, 5'd31, 5'd31, 5'd31, 1'b0);
        tick();
        check_beat("w1", 15'h0000, 5'd0, 5'd0, 5'd0, 1'b1);
        tick();
        check("w.done", done, 1'b1);
        tick();

        // Backpressure: ready pattern 1,0,0,1,0,0,...
        start = 1'b1; start_addr = 15'h0100; count = 16'd4; out_ready = 1'b0;
        tick();
        start = 1'b0;
        hs = 0; stalled = 1'b0; got_done = 1'b0;
        prev_addr = '0; prev_xyz = '0; prev_last = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            if (done) begin
                got_done = 1'b1;
            end else begin
                if (stalled) begin
                    check("bp.hold_valid", out_valid, 1'b1);
                    check("bp.hold", {out_addr, out_x, out_y, out_z, out_last},
                          {prev_addr, prev_xyz[14:0], prev_last});
                end
                out_ready = (i % 3 == 0);
                if (out_valid && out_ready) begin
                    check("bp.addr", out_addr, 15'h0100 + 15'(hs));
                    check("bp.last", out_last, (hs == 3));
                    hs++;
                end
                stalled   = out_valid && !out_ready;
                prev_addr = out_addr;
                prev_xyz  = {1'b0, out_x, out_y, out_z};
                prev_last = out_last;
                tick();
            end
        end
        check("bp.done_seen", got_done, 1'b1);
        check("bp.handshakes", hs, 4);
        out_ready = 1'b1;
        tick();

        // Empty run: no beats, done pulse right after the start edge.
        start = 1'b1; start_addr = 15'h0055; count = 16'd0;
        tick();
        start = 1'b0;
        check("e.valid", out_valid, 1'b0);
        check("e.done", done, 1'b1);
        check("e.busy", busy, 1'b1);
        tick();
        check("e.done_off", done, 1'b0);
        check("e.busy_off", busy, 1'b0);
        check("e.valid_off", out_valid, 1'b0);

        // A second start while running must not reload address or length.
        start = 1'b1; start_addr = 15'h0010; count = 16'd3; out_ready = 1'b0;
        tick();
        start = 1'b1; start_addr = 15'h5555; count = 16'd7;
        check_beat("ig0", 15'h0010, 5'd16, 5'd0, 5'd0, 1'b0);
        tick();
        start = 1'b0; out_ready = 1'b1;
        check_beat("ig0s", 15'h0010, 5'd16, 5'd0, 5'd0, 1'b0);
        tick();
        check_beat("ig1", 15'h0011, 5'd17, 5'd0, 5'd0, 1'b0);
        tick();
        check_beat("ig2", 15'h0012, 5'd18, 5'd0, 5'd0, 1'b1);
        tick();
        check("ig.done", done, 1'b1);
        tick();

        // {x,y,z} packing order on the second instance.
        start = 1'b1; start_addr = 15'h0023; count = 16'd1;
        tick();
        start = 1'b0;
        check("xyz.valid", out_valid0, 1'b1);
        check("xyz.addr", out_addr0, 15'h0023);
        check("xyz.z", out_z0, 5'd3);
        check("xyz.y", out_y0, 5'd1);
        check("xyz.x", out_x0, 5'd0);
        check("xyz.last", out_last0, 1'b1);
        tick();
        check("xyz.done", done0, 1'b1);
        tick();

        // Oversized count clamps to a full-space run that wraps once.
        start = 1'b1; start_addr = 15'h1234; count = 16'hFFFF;
        tick();
        start = 1'b0;
        exp_addr = 15'h1234; beats = 0; seq_err = 0; last_cnt = 0; last_addr = '0;
        for (int i = 0; i < 40000 && !done; i++) begin
            if (out_valid) begin
                if (out_addr !== exp_addr) seq_err++;
                if (out_last) begin
                    last_cnt++;
                    last_addr = out_addr;
                end
                beats++;
                exp_addr = exp_addr + 15'd1;
            end
            tick();
        end
        check("full.done", done, 1'b1);
        check("full.beats", beats, 32768);
        check("full.seq_err", seq_err, 0);
        check("full.last_cnt", last_cnt, 1);
        check("full.last_addr", last_addr, 15'h1233);
        tick();

`ifdef VOXEL_SCAN_ABORT_EN
        // Abort together with the third handshake: that beat counts, then stop.
        start = 1'b1; start_addr = 15'h0200; count = 16'd10;
        tick();
        start = 1'b0;
        check_beat("ab0", 15'h0200, 5'd0, 5'd16, 5'd0, 1'b0);
        tick();
        check_beat("ab1", 15'h0201, 5'd1, 5'd16, 5'd0, 1'b0);
        tick();
        check_beat("ab2", 15'h0202, 5'd2, 5'd16, 5'd0, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab.valid_off", out_valid, 1'b0);
        check("ab.done", done, 1'b1);
        tick();
        check("ab.idle", busy, 1'b0);
        check("ab.no_beat", out_valid, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab.idle_ignored", done, 1'b0);
`endif

        // Reset mid-run clears outputs without a clock edge and gives no done.
        start = 1'b1; start_addr = 15'h0300; count = 16'd5;
        tick();
        start = 1'b0;
        tick();
        check("mr.running", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr.busy", busy, 1'b0);
        check("mr.valid", out_valid, 1'b0);
        check("mr.done", done, 1'b0);
        check("mr.last", out_last, 1'b0);
        check("mr.addr", out_addr, 15'h0);
        check("mr.xyz", {out_x, out_y, out_z}, 15'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mr.no_done", done, 1'b0);
        check("mr.idle", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/voxel_scan_walker.md
# voxel_scan_walker

Sequential address walker and coordinate decoder for the voxel memory. It sits on the read side of the voxel address map, the inverse of the (x,y,z)→address packing. On a start command it steps through a run of linear voxel addresses and emits one beat per address, each carrying the address and its decoded x/y/z, over a valid/ready stream. Scene readback, clear and preload sequencers consume this stream.

## Interface
Parameters:
- X_BITS, 5: x coordinate width (1..16)
- Y_BITS, 5: y coordinate width (1..16)
- Z_BITS, 5: z coordinate width (1..16)
- MAP_ZYX, 1: packing order. 1 = {z,y,x} (x in LSBs); 0 = {x,y,z} (z in LSBs). Must match the address map used by the writer.
- ADDR_BITS (derived) = X_BITS+Y_BITS+Z_BITS, ≤32.

Ports:
- clk, in, 1: single clock, rising edge
- rst_n, in, 1: asynchronous, active-low reset
- start, in, 1: command strobe, sampled in IDLE only
- start_addr, in, ADDR_BITS: first address of the run
- count, in, ADDR_BITS+1: number of beats; 0 = empty run; values >2^ADDR_BITS clamp to 2^ADDR_BITS
- busy, out, 1: high whenever state ≠ IDLE
- done, out, 1: one-cycle pulse at the end of a run
- out_valid, out, 1: beat available
- out_ready, in, 1: consumer accepts the beat
- out_addr, out, ADDR_BITS: linear address of the beat
- out_x / out_y / out_z, out, X_BITS / Y_BITS / Z_BITS: decoded coordinates of out_addr
- out_last, out, 1: final beat of the run
- abort, in, 1: present only with VOXEL_SCAN_ABORT_EN

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - start with count≠0 → RUN. Load cur_addr=start_addr and remaining=min(count, 2^ADDR_BITS).
  - start with count=0 → DONE. No beats are emitted.
  - start is ignored in RUN and DONE.
- RUN:
  - out_valid=1.
  - On out_valid&&out_ready: cur_addr increments modulo 2^ADDR_BITS (0x7FFF→0x0000 for 5/5/5) and remaining decrements.
  - If the accepted beat had out_last=1 → DONE.
- DONE: done=1 for exactly one cycle, then → IDLE.
- out_last = (remaining==1) in RUN.
- Decode for MAP_ZYX=1: x=addr[X_BITS-1:0], y=addr[X_BITS+:Y_BITS], z=addr[X_BITS+Y_BITS+:Z_BITS].
- Decode for MAP_ZYX=0: z=addr[Z_BITS-1:0], y=addr[Z_BITS+:Y_BITS], x=addr[Z_BITS+Y_BITS+:X_BITS].
- Stall rule: while out_valid&&!out_ready, all out_* hold stable. out_valid never drops without a handshake, except on abort or reset.
- A full-space run (count=2^ADDR_BITS) visits every address exactly once, wrapping if start_addr≠0.

## Timing
- All outputs are registered.
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_addr=0, out_x=out_y=out_z=0. State is IDLE.
- Latency:
  - start sampled at edge N → first beat valid and busy=1 after edge N.
  - Empty run: done=1 and busy=1 after edge N, both 0 after edge N+1.
- Throughput: one beat per cycle while out_ready=1.
- done rises on the cycle after the last handshake. busy falls together with done.
- Reset asserted mid-run clears everything immediately. The partial run is lost; there is no done pulse.

## Configuration
- VOXEL_SCAN_ABORT_EN defined:
  - The abort port exists.
  - abort=1 in RUN → DONE at the next edge: out_valid=0, done pulses, no further beats.
  - A handshake in the same cycle as abort counts as delivered.
  - abort in IDLE or DONE is ignored.
- VOXEL_SCAN_ABORT_EN undefined: no abort port, and every started run completes.

## Structure
- Shared package voxel_pkg holds:
  - the scan_state_t enum {IDLE, RUN, DONE}
  - the address-width helper function
  - range-check constants shared with the address map
- Sub-module voxel_addr_unmap: purely combinational addr→(x,y,z) decode with the same parameters. It is reused by other readers.
- Parameter range checks use elaboration-time assertions, matching the address map's limits.

## Test plan
- 5/5/5, MAP_ZYX=1, start_addr=0x0421, count=3, out_ready=1:
  - Beats 0x0421 (1,1,1), 0x0422 (2,1,1), 0x0423 (3,1,1).
  - out_last on the third beat; done one cycle later.
- Wrap: start_addr=0x7FFF, count=2 → beats 0x7FFF (31,31,31), then 0x0000 (0,0,0) with out_last.
- Backpressure: count=4 with out_ready toggling 1,0,0,1,… → each beat held stable while stalled; exactly 4 handshakes; addresses strictly sequential.
- count=0 → no out_valid, done pulse at N+1. A start during RUN is ignored, with no change to cur_addr.
- MAP_ZYX=0, start_addr=0x0023, count=1 → z=3, y=1, x=0, out_last=1.
- With VOXEL_SCAN_ABORT_EN: count=10, abort after the 3rd handshake → out_valid=0 next cycle, done pulse, 3 beats total. Also cover rst_n low mid-run → all outputs return to reset values immediately.
